// File: rtl/ps_head_extractor.sv
// ps_head_extractor
//   Splits each PacketStream packet into a header part and a body part.
//   The first hlen words of a packet, sampled at start-of-packet, go to the
//   header interface (h_*) and are closed with their own eop. Every word after
//   them goes to the body interface (o_*). Routing is combinational, so there
//   is no added latency. Only the packet state is registered.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   extract, hlen       : per-packet extraction enable and header length in words
//                         (hlen == 0 means no extraction); sampled on the first word
//   i_dat/i_val/i_eop   : input stream; i_rdy is the ready of the selected output
//   h_dat/h_val/h_eop   : header stream out, with h_rdy back-pressure
//   o_dat/o_val/o_eop   : body stream out, with o_rdy back-pressure
//   h_short             : one-cycle pulse after a packet ended inside its header
module ps_head_extractor #(
    parameter int WIDTH  = 8,
    parameter int LWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              extract,
    input  logic [LWIDTH-1:0] hlen,
    input  logic [WIDTH-1:0]  i_dat,
    input  logic              i_val,
    input  logic              i_eop,
    output logic              i_rdy,
    output logic [WIDTH-1:0]  h_dat,
    output logic              h_val,
    output logic              h_eop,
    input  logic              h_rdy,
    output logic [WIDTH-1:0]  o_dat,
    output logic              o_val,
    output logic              o_eop,
    input  logic              o_rdy,
    output logic              h_short
);

    typedef enum logic [1:0] {
        ST_START,
        ST_HEAD,
        ST_BODY
    } state_t;

    state_t            state_q, state_d;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic              h_short_q, h_short_d;

    logic              to_head;
    logic              last_head;
    logic              xfer;

    // Routing: in START the decision comes straight from extract/hlen so that
    // the first word is steered with no added latency.
    always_comb begin
        if (state_q == ST_START) begin
            to_head   = extract && (hlen != '0);
            last_head = (hlen == LWIDTH'(1));
        end else begin
            to_head   = (state_q == ST_HEAD);
            last_head = (cnt_q == len_q - LWIDTH'(1));
        end

        h_dat = i_dat;
        o_dat = i_dat;
        h_val = i_val && to_head;
        o_val = i_val && !to_head;
        i_rdy = to_head ? h_rdy : o_rdy;
        h_eop = to_head && (i_eop || last_head);
        o_eop = !to_head && i_eop;
        xfer  = i_val && i_rdy;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        h_short_d = 1'b0;

        if (xfer) begin
            case (state_q)
                ST_START: begin
                    if (to_head) begin
                        len_d = hlen;
                        cnt_d = LWIDTH'(1);
                        if (i_eop) begin
                            state_d   = ST_START;
                            h_short_d = !last_head;
                        end else if (last_head) begin
                            state_d = ST_BODY;
                        end else begin
                            state_d = ST_HEAD;
                        end
                    end else begin
                        state_d = i_eop ? ST_START : ST_BODY;
                    end
                end
                ST_HEAD: begin
                    cnt_d = cnt_q + LWIDTH'(1);
                    if (i_eop) begin
                        state_d   = ST_START;
                        h_short_d = !last_head;
                    end else if (last_head) begin
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (i_eop) begin
                        state_d = ST_START;
                    end
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_START;
            cnt_q     <= '0;
            len_q     <= '0;
            h_short_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            h_short_q <= h_short_d;
        end
    end

    assign h_short = h_short_q;

endmodule

// File: tb/tb_ps_head_extractor.sv
// Testbench for ps_head_extractor: directed vector table, hand-written
// corner sequences and randomized traffic against a word-position model.
module tb_ps_head_extractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       extract;
    logic [7:0] hlen;
    logic [7:0] i_dat;
    logic       i_val, i_eop, i_rdy;
    logic [7:0] h_dat, o_dat;
    logic       h_val, h_eop, h_rdy;
    logic       o_val, o_eop, o_rdy;
    logic       h_short;

    int errors = 0;
    int checks = 0;

    // Model state: position of the next word in its packet and the
    // extraction settings captured on that packet's first word.
    int   pos       = 0;
    logic cur_ext   = 1'b0;
    int   cur_hlen  = 0;
    logic exp_short = 1'b0;
    int   h_words   = 0;
    int   o_words   = 0;

    ps_head_extractor #(.WIDTH(8), .LWIDTH(8)) dut (
        .clk(clk), .reset(reset), .extract(extract), .hlen(hlen),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .h_dat(h_dat), .h_val(h_val), .h_eop(h_eop), .h_rdy(h_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
        .h_short(h_short)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check the routing against the model at the
    // falling edge, then advance the model. obs = {h_val,o_val,h_eop,o_eop,h_short,i_rdy}.
    task automatic cycle(input logic v, input logic e, input logic [7:0] d,
                         input logic ext, input logic [7:0] hl,
                         input logic hr, input logic orr,
                         output logic [5:0] obs);
        logic first, eff_ext, th, last, rdy, xf, nshort;
        int   eff_hlen;
        i_val = v; i_eop = e; i_dat = d; extract = ext; hlen = hl;
        h_rdy = hr; o_rdy = orr;
        @(negedge clk);
        first    = (pos == 0);
        eff_ext  = first ? (ext && hl != 0) : cur_ext;
        eff_hlen = first ? int'(hl) : cur_hlen;
        th       = eff_ext && (pos < eff_hlen);
        last     = th && (pos == eff_hlen - 1);
        rdy      = th ? hr : orr;
        chk("h_val", h_val, v && th);
        chk("o_val", o_val, v && !th);
        chk("i_rdy", i_rdy, rdy);
        chk("h_eop", h_eop, th && (e || last));
        chk("o_eop", o_eop, !th && e);
        chk("h_dat", h_dat, d);
        chk("o_dat", o_dat, d);
        chk("h_short", h_short, exp_short);
        obs = {h_val, o_val, h_eop, o_eop, h_short, i_rdy};
        xf     = v && rdy;
        nshort = xf && th && e && !last;
        if (h_val && h_rdy) h_words++;
        if (o_val && o_rdy) o_words++;
        if (xf) begin
            if (first) begin
                cur_ext  = eff_ext;
                cur_hlen = eff_hlen;
            end
            pos = e ? 0 : pos + 1;
        end
        @(posedge clk);
        #1;
        exp_short = nshort;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_val = 1'b0; i_eop = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pos = 0; exp_short = 1'b0;
    endtask

    typedef struct {
        logic       v, e;
        logic [7:0] d;
        logic       ext;
        logic [7:0] hl;
        logic [5:0] exp; // {h_val,o_val,h_eop,o_eop,h_short,i_rdy}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic e, input logic [7:0] d,
                                input logic ext, input logic [7:0] hl, input logic [5:0] exp);
        vec_t r;
        r.v = v; r.e = e; r.d = d; r.ext = ext; r.hl = hl; r.exp = exp;
        return r;
    endfunction

    initial begin
        logic [5:0] obs;
        logic       pkt_ext;
        logic [7:0] pkt_hl;

        reset = 1'b1; i_val = 1'b0; i_eop = 1'b0; i_dat = '0;
        extract = 1'b0; hlen = '0; h_rdy = 1'b1; o_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state: idle, no pulse
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b1, obs);
        chk("reset_idle", obs, 6'b000001);

        // 1: hlen=2, 6 words
        tbl.push_back(mk(1, 0, 8'h10, 1, 2, 6'b100001));
        tbl.push_back(mk(1, 0, 8'h11, 1, 2, 6'b101001));
        tbl.push_back(mk(1, 0, 8'h12, 1, 2, 6'b010001));
        tbl.push_back(mk(1, 0, 8'h13, 1, 2, 6'b010001));
        tbl.push_back(mk(1, 0, 8'h14, 1, 2, 6'b010001));
        tbl.push_back(mk(1, 1, 8'h15, 1, 2, 6'b010101));
        // 2: extract=0, then extract=1 with hlen=0
        tbl.push_back(mk(1, 0, 8'h20, 0, 3, 6'b010001));
        tbl.push_back(mk(1, 0, 8'h21, 0, 3, 6'b010001));
        tbl.push_back(mk(1, 0, 8'h22, 0, 3, 6'b010001));
        tbl.push_back(mk(1, 1, 8'h23, 0, 3, 6'b010101));
        tbl.push_back(mk(1, 0, 8'h24, 1, 0, 6'b010001));
        tbl.push_back(mk(1, 0, 8'h25, 1, 0, 6'b010001));
        tbl.push_back(mk(1, 0, 8'h26, 1, 0, 6'b010001));
        tbl.push_back(mk(1, 1, 8'h27, 1, 0, 6'b010101));
        // 3: hlen=4, 2-word packet -> short header pulse
        tbl.push_back(mk(1, 0, 8'h30, 1, 4, 6'b100001));
        tbl.push_back(mk(1, 1, 8'h31, 1, 4, 6'b101001));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'b000011));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'b000001));
        // 4: header equals whole packet, then back-to-back hlen=1
        tbl.push_back(mk(1, 0, 8'h40, 1, 3, 6'b100001));
        tbl.push_back(mk(1, 0, 8'h41, 1, 3, 6'b100001));
        tbl.push_back(mk(1, 1, 8'h42, 1, 3, 6'b101001));
        tbl.push_back(mk(1, 0, 8'h50, 1, 1, 6'b101001));
        tbl.push_back(mk(1, 0, 8'h51, 1, 1, 6'b010001));
        tbl.push_back(mk(1, 1, 8'h52, 1, 1, 6'b010101));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'b000001));

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].ext, tbl[i].hl, 1'b1, 1'b1, obs);
            chk($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // 5: back-pressure on the header, hlen changed mid-packet
        h_words = 0; o_words = 0;
        cycle(1'b1, 1'b0, 8'h60, 1'b1, 8'd2, 1'b1, 1'b1, obs);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 8'h61, 1'b1, 8'd7, 1'b0, 1'b1, obs);
            chk("hstall_rdy", obs[0], 1'b0);
        end
        cycle(1'b1, 1'b0, 8'h61, 1'b1, 8'd7, 1'b1, 1'b0, obs);
        chk("hstall_done", obs, 6'b101001);
        for (int k = 0; k < 3; ) begin
            logic orr;
            orr = 1'($urandom_range(0, 1));
            cycle(1'b1, (k == 2), 8'(8'h62 + k), 1'b1, 8'd7, 1'b0, orr, obs);
            chk("body_rdy", obs[0], orr);
            chk("body_route", obs[4], 1'b1);
            if (orr) k++;
        end
        chk("bp_hwords", h_words, 2);
        chk("bp_owords", o_words, 3);

        // 6: reset in body after 2 body words
        cycle(1'b1, 1'b0, 8'h70, 1'b1, 8'd1, 1'b1, 1'b1, obs);
        cycle(1'b1, 1'b0, 8'h71, 1'b1, 8'd1, 1'b1, 1'b1, obs);
        cycle(1'b1, 1'b0, 8'h72, 1'b1, 8'd1, 1'b1, 1'b1, obs);
        do_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b1, obs);
        chk("rst_idle", obs, 6'b000001);
        cycle(1'b1, 1'b0, 8'h80, 1'b1, 8'd1, 1'b1, 1'b1, obs);
        chk("rst_next_head", obs, 6'b101001);
        cycle(1'b1, 1'b1, 8'h81, 1'b1, 8'd1, 1'b1, 1'b1, obs);
        chk("rst_next_body", obs, 6'b010101);

        // randomized traffic; settings stay stable while a first word is stalled
        pkt_ext = 1'($urandom_range(0, 3) != 0);
        pkt_hl  = 8'($urandom_range(0, 6));
        for (int n = 0; n < 3000; n++) begin
            logic v, e, hr, orr, ext;
            logic [7:0] hl;
            v   = ($urandom_range(0, 3) != 0);
            e   = ($urandom_range(0, 3) == 0);
            hr  = 1'($urandom_range(0, 1));
            orr = 1'($urandom_range(0, 1));
            if (pos == 0) begin
                ext = pkt_ext; hl = pkt_hl;
            end else begin
                ext = 1'($urandom_range(0, 1)); hl = 8'($urandom);
            end
            cycle(v, e, 8'($urandom), ext, hl, hr, orr, obs);
            if (v && obs[0] && e) begin
                pkt_ext = 1'($urandom_range(0, 3) != 0);
                pkt_hl  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255))
                                                       : 8'($urandom_range(0, 6));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
